micro_sequencer: RTL and testbench
==================================

# micro_sequencer

Microprogram sequencer for the multi-cycle RISC-V (RV32I + MUL) core. It accepts one instruction at a time and decodes it into a 5-bit routine code. It then steps a micro-PC through that routine's microcode words until the ROM marks the end of the routine. It also resolves conditional branches from ALU flags, stalls for a configurable multiplier latency, and traps on illegal encodings. It sits between the fetch stage and the microcode ROM.

## Interface
- STEP_W, default 3: micro-step bits; each routine spans at most 2^STEP_W words.
- MUL_LAT, default 4, ≥1: cycles the multiplier needs after its issue word.
- clk, input, 1: clock, rising edge.
- rst_n, input, 1: synchronous, active-low reset, sampled on the rising edge of clk.
- ins_valid, input, 1: fetch offers an instruction.
- ins_ready, output, 1: sequencer accepts; transfer occurs when ins_valid & ins_ready.
- ins, input, 32: instruction word, sampled at transfer.
- zero, blt, bge, ltu, geu, inputs, 1 each: ALU compare flags for the current branch operands.
- u_end, input, 1: ROM bit; the word at uaddr is the last of its routine.
- uaddr, output, 5+STEP_W: microcode address = {code[4:0], step}.
- uop_valid, output, 1: uaddr is a live micro-op this cycle.
- illegal, output, 1: one-cycle pulse on illegal instruction or step overrun.
- busy, output, 1: high in any state other than IDLE.

## Operation
- Decode at transfer; the code is registered.
  - OP (0110011): add=1, sub=2, slt=3, sltu=4, xor=5, or=6, and=7, sll=8, srl=9, sra=10, mul (func7=0000001, func3=000)=25.
  - OP-IMM (0010011): addi=11, slti=12, sltiu=13, xori=14, ori=15, andi=16. slli=17, srli=18, srai=19, each requiring func7 0000000/0000000/0100000.
  - load (0000011)=20; store (0100011)=21.
  - Any branch (1100011) with func3 in {000,001,100,101,110,111` }=29 (compare routine).
  - jalr (1100111, func3=000)=24; jal (1101111)=26; lui (0110111)=27; auipc (0010111)=28.
  - Every other encoding =0 (illegal).
- States: IDLE, RUN, MULW, BRRES, TRAP.
- IDLE: ins_ready=1. On transfer with code≠0 → RUN, step=0. On transfer with code=0 → TRAP.
- RUN: uop_valid=1, uaddr={code,step}.
  - If u_end=1: code 29 → BRRES; any other code → IDLE.
  - Else if code=25 and step=0 → MULW with a counter loaded to MUL_LAT.
  - Else step+1. If step=2^STEP_W−1 and u_end=0: forced end, illegal pulse, → IDLE.
- MULW: uop_valid=0; uaddr holds {25,0}. The counter decrements each cycle; at 1 → RUN, step=1.
- BRRES: samples the flags once. taken = beq:zero, bne:!zero, blt:blt, bge:bge, bltu:ltu, bgeu:geu. Sets code=23 if taken, else 22; step=0 → RUN.
- TRAP: illegal=1, uop_valid=0 for one cycle → IDLE.
- Step arithmetic is unsigned STEP_W-bit. Overflow never wraps into a new routine.

## Timing
- Reset (rst_n=0 at an edge): state=IDLE, uaddr=0, uop_valid=0, illegal=0, busy=0. ins_ready=(state==IDLE)&rst_n, so it is 0 while rst_n is low.
- Reset mid-routine aborts the routine the next edge. No pending illegal pulse survives reset.
- Transfer at edge T: first micro-op (uop_valid=1) appears in cycle T+1. ins_ready is 0 from T+1 until the cycle after the final u_end.
- An N-word non-mul routine occupies N cycles. The next transfer can occur at the edge ending the u_end cycle+1, i.e. one IDLE cycle between instructions.
- mul: step 0, then MUL_LAT cycles with uop_valid=0, then step 1 onward.
- Branch: compare routine, then one BRRES cycle (uop_valid=0), then routine 22/23. Flags must be stable in the BRRES cycle.
- An illegal instruction gives one busy cycle with the illegal pulse, then IDLE.
- ins_valid without ins_ready is ignored. ins may change freely when no transfer occurs.

## Test plan
- Reset then add x1,x2,x3 (0x003100B3) with u_end on step 1 → uaddr 0x08 then 0x09 (STEP_W=3), uop_valid 2 cycles, ins_ready back after 1 IDLE-cycle boundary.
- mul (0x023100B3), MUL_LAT=4, u_end at step 2 → uaddr {25,0}, 4 cycles uop_valid=0, then {25,1},{25,2}; busy for 7 cycles.
- Branch pass/fail: beq with zero=1 in BRRES → routine 23. bne with zero=1 → 22. bltu with ltu=1 → 23. bgeu with geu=0 → 22.
- Illegal word 0xFFFFFFFF → single illegal pulse, no uop_valid, ins_ready 1 two cycles after transfer. andi (func3=111, 0010011) → code 16, not illegal.
- Overrun: u_end held 0 → 8 micro-ops (step 0–7), illegal pulse on the step-7 cycle, then IDLE.
- Reset asserted on step 1 of a load routine → next cycle uop_valid=0, uaddr=0, busy=0. A subsequent sub (0x403100B3) runs from {2,0}.

Source files
------------

// File: rtl/micro_sequencer.sv
// micro_sequencer: decodes RV32I+MUL instructions into microcode routines and steps the micro-PC
// through them, with branch resolution, multiplier wait and illegal-instruction trapping.
module micro_sequencer #(
  parameter int STEP_W  = 3,
  parameter int MUL_LAT = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ins_valid,
  output logic              ins_ready,
  input  logic [31:0]       ins,
  input  logic              zero,
  input  logic              blt,
  input  logic              bge,
  input  logic              ltu,
  input  logic              geu,
  input  logic              u_end,
  output logic [STEP_W+4:0] uaddr,
  output logic              uop_valid,
  output logic              illegal,
  output logic              busy
);
  localparam int CW = $clog2(MUL_LAT + 1);
  typedef enum logic [2:0] {IDLE, RUN, MULW, BRRES, TRAP} state_t;
  state_t            state_q, state_d;
  logic [4:0]        code_q, code_d, dec;
  logic [STEP_W-1:0] step_q, step_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [2:0]        f3_q, f3_d;
  logic [6:0]        op, f7;
  logic [2:0]        f3;
  logic              taken, overrun, unused_ins;
  assign op         = ins[6:0];
  assign f3         = ins[14:12];
  assign f7         = ins[31:25];
  assign unused_ins = ^{ins[24:15], ins[11:7]};
  always_comb begin
    dec = 5'd0;
    case (op)
      7'b0110011:
        if (f7 == 7'b0000000)
          case (f3)
            3'b000:  dec = 5'd1;
            3'b001:  dec = 5'd8;
            3'b010:  dec = 5'd3;
            3'b011:  dec = 5'd4;
            3'b100:  dec = 5'd5;
            3'b101:  dec = 5'd9;
            3'b110:  dec = 5'd6;
            default: dec = 5'd7;
          endcase
        else if (f7 == 7'b0100000)
          dec = (f3 == 3'b000) ? 5'd2 : (f3 == 3'b101) ? 5'd10 : 5'd0;
        else if (f7 == 7'b0000001 && f3 == 3'b000)
          dec = 5'd25;
      7'b0010011:
        case (f3)
          3'b000:  dec = 5'd11;
          3'b001:  dec = (f7 == 7'b0000000) ? 5'd17 : 5'd0;
          3'b010:  dec = 5'd12;
          3'b011:  dec = 5'd13;
          3'b100:  dec = 5'd14;
          3'b101:  dec = (f7 == 7'b0000000) ? 5'd18 : (f7 == 7'b0100000) ? 5'd19 : 5'd0;
          3'b110:  dec = 5'd15;
          default: dec = 5'd16;
        endcase
      7'b0000011: dec = 5'd20;
      7'b0100011: dec = 5'd21;
      7'b1100011: dec = (f3 == 3'b010 || f3 == 3'b011) ? 5'd0 : 5'd29;
      7'b1100111: dec = (f3 == 3'b000) ? 5'd24 : 5'd0;
      7'b1101111: dec = 5'd26;
      7'b0110111: dec = 5'd27;
      7'b0010111: dec = 5'd28;
      default:    dec = 5'd0;
    endcase
  end
  always_comb begin
    case (f3_q)
      3'b000:  taken = zero;
      3'b001:  taken = !zero;
      3'b100:  taken = blt;
      3'b101:  taken = bge;
      3'b110:  taken = ltu;
      3'b111:  taken = geu;
      default: taken = 1'b0;
    endcase
  end
  // A routine that reaches its last step without u_end is cut short rather than wrapping.
  assign overrun = (state_q == RUN) && !u_end && (&step_q);
  always_comb begin
    state_d = state_q;
    code_d  = code_q;
    step_d  = step_q;
    cnt_d   = cnt_q;
    f3_d    = f3_q;
    case (state_q)
      IDLE:
        if (ins_valid) begin
          code_d  = dec;
          step_d  = '0;
          f3_d    = f3;
          state_d = (dec != 5'd0) ? RUN : TRAP;
        end
      RUN:
        if (u_end)
          state_d = (code_q == 5'd29) ? BRRES : IDLE;
        else if (code_q == 5'd25 && step_q == '0) begin
          state_d = MULW;
          cnt_d   = CW'(MUL_LAT);
        end else if (overrun)
          state_d = IDLE;
        else
          step_d = step_q + 1'b1;
      MULW: begin
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CW'(1)) begin
          state_d = RUN;
          step_d  = STEP_W'(1);
        end
      end
      BRRES: begin
        code_d  = taken ? 5'd23 : 5'd22;
        step_d  = '0;
        state_d = RUN;
      end
      TRAP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk)
    if (!rst_n) begin
      state_q <= IDLE;
      code_q  <= '0;
      step_q  <= '0;
      cnt_q   <= '0;
      f3_q    <= '0;
    end else begin
      state_q <= state_d;
      code_q  <= code_d;
      step_q  <= step_d;
      cnt_q   <= cnt_d;
      f3_q    <= f3_d;
    end
  assign ins_ready = (state_q == IDLE) && rst_n;
  assign uaddr     = {code_q, step_q};
  assign uop_valid = (state_q == RUN);
  assign illegal   = (state_q == TRAP) || overrun;
  assign busy      = (state_q != IDLE);
endmodule

// File: tb/tb_micro_sequencer.sv
// tb_micro_sequencer: directed checks of decode, stepping, mul wait, branch resolution, traps and reset.
module tb_micro_sequencer;
  logic        clk = 1'b0;
  logic        rst_n, ins_valid, ins_ready;
  logic [31:0] ins;
  logic        zero, blt, bge, ltu, geu, u_end;
  logic [7:0]  uaddr;
  logic        uop_valid, illegal, busy;
  logic        end_en;
  logic [2:0]  end_step;
  int          n_tests = 0;
  int          n_fail  = 0;
  micro_sequencer #(.STEP_W(3), .MUL_LAT(4)) dut (
    .clk(clk), .rst_n(rst_n), .ins_valid(ins_valid), .ins_ready(ins_ready), .ins(ins),
    .zero(zero), .blt(blt), .bge(bge), .ltu(ltu), .geu(geu), .u_end(u_end),
    .uaddr(uaddr), .uop_valid(uop_valid), .illegal(illegal), .busy(busy)
  );
  always #5 clk = ~clk;
  // Stand-in for the microcode ROM: flags the chosen step of every routine as its last word.
  assign u_end = end_en && uop_valid && (uaddr[2:0] == end_step);
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic send(input logic [31:0] w);
    ins       = w;
    ins_valid = 1'b1;
    tick();
    ins_valid = 1'b0;
    ins       = 32'hDEAD_BEEF;
  endtask
  task automatic branch(input string tag, input logic [31:0] w, input logic z, input logic l,
                        input logic g, input logic [7:0] exp_addr);
    end_en = 1'b1; end_step = 3'd0;
    send(w);
    check({tag, "_cmp"}, uaddr, 8'hE8);
    zero = z; ltu = l; geu = g;
    tick();
    check({tag, "_brres_valid"}, uop_valid, 1'b0);
    check({tag, "_brres_busy"}, busy, 1'b1);
    tick();
    zero = 1'b0; ltu = 1'b0; geu = 1'b0;
    check({tag, "_target"}, uaddr, exp_addr);
    check({tag, "_target_valid"}, uop_valid, 1'b1);
    tick();
    check({tag, "_idle"}, ins_ready, 1'b1);
  endtask
  initial begin
    rst_n = 1'b0; ins_valid = 1'b0; ins = '0;
    zero = 1'b0; blt = 1'b0; bge = 1'b0; ltu = 1'b0; geu = 1'b0;
    end_en = 1'b0; end_step = 3'd0;
    tick(); tick();
    check("rst_ready", ins_ready, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_valid", uop_valid, 1'b0);
    check("rst_uaddr", uaddr, 8'h00);
    check("rst_illegal", illegal, 1'b0);
    rst_n = 1'b1;
    #1;
    check("idle_ready", ins_ready, 1'b1);
    end_en = 1'b1; end_step = 3'd1;
    send(32'h003100B3);
    check("add_s0", uaddr, 8'h08);
    check("add_s0_valid", uop_valid, 1'b1);
    check("add_busy_ready", ins_ready, 1'b0);
    tick();
    check("add_s1", uaddr, 8'h09);
    check("add_s1_valid", uop_valid, 1'b1);
    tick();
    check("add_done_ready", ins_ready, 1'b1);
    check("add_done_busy", busy, 1'b0);
    end_step = 3'd2;
    send(32'h023100B3);
    check("mul_s0", uaddr, 8'hC8);
    check("mul_s0_valid", uop_valid, 1'b1);
    for (int i = 0; i < 4; i++) begin
      tick();
      check($sformatf("mul_wait%0d_valid", i), uop_valid, 1'b0);
      check($sformatf("mul_wait%0d_uaddr", i), uaddr, 8'hC8);
      check($sformatf("mul_wait%0d_busy", i), busy, 1'b1);
    end
    tick();
    check("mul_s1", {uop_valid, uaddr}, {1'b1, 8'hC9});
    tick();
    check("mul_s2", {uop_valid, uaddr}, {1'b1, 8'hCA});
    tick();
    check("mul_done_busy", busy, 1'b0);
    branch("beq_taken", 32'h00000063, 1'b1, 1'b0, 1'b0, 8'hB8);
    branch("bne_not", 32'h00001063, 1'b1, 1'b0, 1'b0, 8'hB0);
    branch("bltu_taken", 32'h00006063, 1'b0, 1'b1, 1'b0, 8'hB8);
    branch("bgeu_not", 32'h00007063, 1'b0, 1'b0, 1'b0, 8'hB0);
    send(32'hFFFFFFFF);
    check("ill_pulse", illegal, 1'b1);
    check("ill_valid", uop_valid, 1'b0);
    check("ill_busy", busy, 1'b1);
    check("ill_ready", ins_ready, 1'b0);
    tick();
    check("ill_pulse_end", illegal, 1'b0);
    check("ill_ready_back", ins_ready, 1'b1);
    send(32'h00002063 | 32'h00001000);
    check("br_f3_011_illegal", illegal, 1'b1);
    tick();
    end_step = 3'd0;
    send(32'h00007013);
    check("andi_uaddr", uaddr, 8'h80);
    check("andi_legal", illegal, 1'b0);
    check("andi_valid", uop_valid, 1'b1);
    tick();
    end_en = 1'b0;
    send(32'h003100B3);
    for (int i = 0; i < 8; i++) begin
      check($sformatf("ovr_s%0d", i), {uop_valid, uaddr}, {1'b1, 8'(8 + i)});
      check($sformatf("ovr_ill%0d", i), illegal, (i == 7) ? 1'b1 : 1'b0);
      tick();
    end
    check("ovr_idle_busy", busy, 1'b0);
    check("ovr_idle_ill", illegal, 1'b0);
    end_en = 1'b1; end_step = 3'd3;
    send(32'h00002003);
    check("ld_s0", uaddr, 8'hA0);
    tick();
    check("ld_s1", uaddr, 8'hA1);
    rst_n = 1'b0;
    tick();
    check("ld_rst_valid", uop_valid, 1'b0);
    check("ld_rst_uaddr", uaddr, 8'h00);
    check("ld_rst_busy", busy, 1'b0);
    check("ld_rst_ready", ins_ready, 1'b0);
    rst_n = 1'b1;
    end_step = 3'd0;
    send(32'h403100B3);
    check("sub_s0", {uop_valid, uaddr}, {1'b1, 8'h10});
    tick();
    check("sub_done", ins_ready, 1'b1);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
